pci_initiator: RTL and testbench
================================

# pci_initiator

PCI bus-master (initiator) front end that sits on the requesting side of the round-robin bus arbiter. On a local `start` it drives `_req`, waits for `_gnt`, runs one address phase and a burst of 1–15 data phases using `_frame`/`_irdy` against the target's `_trdy`/`_devsel`, then releases the bus. Local status is reported on `done` and `abort`. One instance per bus device (Device0..Device2).

## Interface
- `TRDY_TIMEOUT`, 8: data-phase wait cycles without `_trdy` before master abort.
- `DEVSEL_LIMIT`, 5: cycles after address phase allowed for `_devsel`. Used only with `PCI_DEVSEL_CHECK_EN`.
- `clk` input 1: bus clock. All logic samples on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: local transaction request, sampled in IDLE.
- `burst_len` input 4: number of data phases, 1..15. Sampled with `start`.
- `_gnt` input 1: arbiter grant, active low.
- `_trdy` input 1: target ready, active low.
- `_devsel` input 1: target device select, active low.
- `_req` output 1: bus request, active low.
- `_frame` output 1: FRAME#, active low.
- `_irdy` output 1: IRDY#, active low.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the last data phase completes.
- `abort` output 1: one-cycle pulse when a master abort is taken.
- `beat` output 4: count of completed data phases in the current transaction.

## Operation
- All outputs are registered. Reset values: `_req`=1, `_frame`=1, `_irdy`=1, `busy`=0, `done`=0, `abort`=0, `beat`=0. State resets to IDLE.
- States and behaviour:
  - **IDLE**: `_req`/`_frame`/`_irdy` all high. If `start`=1 and `burst_len`≠0: latch `burst_len` into `remaining`, clear `beat`, go to REQ. If `burst_len`=0, `start` is ignored.
  - **REQ**: `_req`=0. On `_gnt`=0, go to ADDR. No timeout; the master waits indefinitely.
  - **ADDR**: one cycle. `_frame`=0, `_irdy`=1, `_req`=1 (request dropped once the bus is owned). Go to DATA.
  - **DATA**: `_irdy`=0. `_frame`=0 while `remaining`>1; `_frame`=1 during the final data phase.
    - A cycle with `_trdy`=0 completes one beat: `beat`+1, `remaining`−1, wait counter cleared.
    - When the beat with `remaining`=1 completes: pulse `done`, go to TURN.
    - A cycle with `_trdy`=1 increments the wait counter. When the counter reaches `TRDY_TIMEOUT`, go to ABORT.
  - **ABORT**: one cycle. `_frame`=1, `_irdy`=0 (FRAME# deasserts before IRDY#). Pulse `abort`. Go to TURN.
  - **TURN**: one cycle. All bus outputs high. Go to IDLE.
- Loss of `_gnt` after ADDR is ignored. The burst runs to completion or abort.
- `start` asserted while `busy`=1 is ignored (not queued).
- `done` and `abort` never pulse in the same cycle.
- `beat` holds its final value until the next accepted `start`. It saturates at 15.
- `reset` asserted in any state returns all outputs to their reset values on the next edge. A transaction interrupted this way produces neither `done` nor `abort`.

## Timing
- `start` sampled at edge 0 → `_req`=0 after edge 1.
- `_gnt`=0 sampled at edge k → `_frame`=0 after edge k+1. This is well inside the arbiter's 16-cycle FRAME# window.
- Address phase lasts exactly 1 cycle. The first data phase begins at edge k+2.
- Zero-wait burst of N beats: bus owned for 1+N cycles. `done` goes high one cycle after the final `_trdy`=0 sample, then one TURN cycle follows.
- Abort with no `_trdy`: `abort` goes high at data-phase entry + `TRDY_TIMEOUT` + 1 cycles.

## Configuration
- `PCI_DEVSEL_CHECK_EN` defined:
  - A DEVSEL counter runs from ADDR exit.
  - If `_devsel` is still 1 after `DEVSEL_LIMIT` DATA cycles, go to ABORT. This takes precedence over the TRDY timeout when both fire in the same cycle.
  - Once `_devsel`=0 has been seen, the counter stops for the rest of the transaction.
- Not defined: `_devsel` is unused and only the TRDY timeout can abort.

## Structure
- Shared package `pci_pkg` holds:
  - the state enum (IDLE, REQ, ADDR, DATA, ABORT, TURN);
  - the 4-bit beat width constant;
  - the default `TRDY_TIMEOUT` and `DEVSEL_LIMIT` values, also used by the arbiter bench.
- One sub-module, `pci_init_timer`: a loadable wait counter with clear and terminal-count output. It is instantiated once for TRDY and, with `PCI_DEVSEL_CHECK_EN`, once for DEVSEL.

## Test plan
- **Reset**: reset held 2 cycles during DATA → next cycle `_req`=`_frame`=`_irdy`=1, `busy`=0, `beat`=0, no `done`/`abort` pulse.
- **Single beat**: `start`, `burst_len`=1, `_gnt`=0 one cycle after `_req` falls, `_trdy`=0 → `_frame` low for exactly the address cycle, `_irdy` low 1 cycle, `done` pulse, `beat`=1.
- **Burst with wait**: `burst_len`=4, `_trdy` high on the 2nd data cycle only → 5 DATA cycles, `_frame` high only during the 4th beat, `beat`=4, `done` once.
- **TRDY timeout**: `burst_len`=3, `_trdy` held high → ABORT after 8 wait cycles, `_frame`=1/`_irdy`=0 for one cycle, `abort` pulse, `beat`=0.
- **Ignored requests**: `start` with `burst_len`=0 → stays IDLE. `start` while `busy`=1 → no second `_req` cycle after TURN.
- **DEVSEL check** (`PCI_DEVSEL_CHECK_EN`): `_devsel` held high → `abort` after 5 DATA cycles. With `_devsel`=0 on the 2nd DATA cycle → normal `done`.

Source files
------------

// File: rtl/pci_initiator_pkg.sv
// rtl/pci_initiator_pkg.sv - shared types and defaults for the PCI initiator
package pci_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_ABORT,
    ST_TURN
  } state_t;

  localparam int BEAT_W           = 4;
  localparam int TRDY_TIMEOUT_DEF = 8;
  localparam int DEVSEL_LIMIT_DEF = 5;

  // Beat counter increment that sticks at all-ones.
  function automatic logic [BEAT_W-1:0] beat_inc(input logic [BEAT_W-1:0] b);
    return (b == {BEAT_W{1'b1}}) ? b : b + 1'b1;
  endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// rtl/pci_initiator_if.sv - PCI initiator bus signals (active-low) with master/slave views
interface pci_initiator_if;
  logic _req;
  logic _frame;
  logic _irdy;
  logic _gnt;
  logic _trdy;
  logic _devsel;

  modport master (output _req, _frame, _irdy, input _gnt, _trdy, _devsel);
  modport slave  (input _req, _frame, _irdy, output _gnt, _trdy, _devsel);
endinterface

// File: rtl/pci_init_timer.sv
// rtl/pci_init_timer.sv - loadable down-counting wait timer with clear and terminal count
module pci_init_timer #(
  parameter int unsigned LIMIT = 8,
  parameter int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count_q, count_d;

  // tc flags the enabled cycle that exhausts the loaded budget; a cleared timer never fires.
  assign tc = en && (count_q == W'(1));

  // Clear parks the counter at zero, load arms it, enable spends one unit.
  always_comb begin
    count_d = count_q;
    if (clear)                       count_d = '0;
    else if (load)                   count_d = W'(LIMIT);
    else if (en && count_q != '0)    count_d = count_q - W'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/pci_initiator.sv
// rtl/pci_initiator.sv - PCI bus-master front end; PCI_DEVSEL_CHECK_EN enables the DEVSEL abort
module pci_initiator
  import pci_pkg::*;
#(
  parameter int unsigned TRDY_TIMEOUT = TRDY_TIMEOUT_DEF,
  parameter int unsigned DEVSEL_LIMIT = DEVSEL_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BEAT_W-1:0] burst_len,
  pci_initiator_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic [BEAT_W-1:0] beat
);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] remaining_q, remaining_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic req_q, req_d, frame_q, frame_d, irdy_q, irdy_d;
  logic busy_q, busy_d, done_q, done_d, abort_q, abort_d;

  logic trdy_load, trdy_en, trdy_tc;
  logic dev_abort;

  // TRDY wait budget is re-armed on the address phase and after every completed beat.
  assign trdy_load = (state_q == ST_ADDR) || (state_q == ST_DATA && !bus._trdy);
  assign trdy_en   = (state_q == ST_DATA) && bus._trdy;

  pci_init_timer #(.LIMIT(TRDY_TIMEOUT)) u_trdy_timer (
    .clk   (clk),
    .reset (reset),
    .load  (trdy_load),
    .clear (1'b0),
    .en    (trdy_en),
    .tc    (trdy_tc)
  );

`ifdef PCI_DEVSEL_CHECK_EN
  logic dev_load, dev_clr, dev_en;
  // Once the target claims the cycle the DEVSEL timer is cleared and stays dormant.
  assign dev_load = (state_q == ST_ADDR);
  assign dev_en   = (state_q == ST_DATA) && bus._devsel;
  assign dev_clr  = (state_q == ST_DATA) && !bus._devsel;

  pci_init_timer #(.LIMIT(DEVSEL_LIMIT)) u_devsel_timer (
    .clk   (clk),
    .reset (reset),
    .load  (dev_load),
    .clear (dev_clr),
    .en    (dev_en),
    .tc    (dev_abort)
  );
`else
  localparam int unsigned unused_devsel_limit = DEVSEL_LIMIT;
  logic unused_devsel;
  assign unused_devsel = bus._devsel;
  assign dev_abort     = 1'b0;
`endif

  // Next state, transaction bookkeeping and registered output values.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && burst_len != '0) begin
          remaining_d = burst_len;
          beat_d      = '0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ:  if (!bus._gnt) state_d = ST_ADDR;
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        if (dev_abort) begin
          state_d = ST_ABORT;
        end else if (!bus._trdy) begin
          beat_d      = beat_inc(beat_q);
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == 4'd1) begin
            done_d  = 1'b1;
            state_d = ST_TURN;
          end
        end else if (trdy_tc) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        abort_d = 1'b1;
        state_d = ST_TURN;
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_d   = (state_q != ST_REQ);
    frame_d = !((state_q == ST_ADDR) || (state_q == ST_DATA && remaining_q > 4'd1));
    irdy_d  = !((state_q == ST_DATA) || (state_q == ST_ABORT));
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      beat_q      <= '0;
      req_q       <= 1'b1;
      frame_q     <= 1'b1;
      irdy_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      req_q       <= req_d;
      frame_q     <= frame_d;
      irdy_q      <= irdy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign bus._req   = req_q;
  assign bus._frame = frame_q;
  assign bus._irdy  = irdy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign abort      = abort_q;
  assign beat       = beat_q;

endmodule

// File: tb/tb_pci_initiator.sv
// tb/tb_pci_initiator.sv - randomized self-checking bench for pci_initiator
module tb_pci_initiator;
  import pci_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] burst_len = 4'd0;
  logic       busy, done, abort;
  logic [3:0] beat;

  pci_initiator_if bus ();

  pci_initiator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .burst_len (burst_len),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .abort     (abort),
    .beat      (beat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    int frame_low; int irdy_low; int fhil; int done_n; int abort_n; int end_cyc;
    int beat; int busy0; int req0; int req1; int req_err; int idle_ok; int fin; int both;
  } res_t;

  bit trdy_seq [200];
  bit dsel_seq [200];

  // Transaction outcome from the data-phase rules: one entry per DATA cycle.
  function automatic res_t model(input int len);
    res_t r;
    int rem, waits, beats, n;
    bit fin, ab;
`ifdef PCI_DEVSEL_CHECK_EN
    int dcnt = 0;
    bit seen = 0;
`endif
    r = '{default: 0};
    r.end_cyc = -1; r.busy0 = 1; r.req0 = 1; r.req1 = 0; r.idle_ok = 1; r.fin = 1;
    r.frame_low = 1;
    rem = len; waits = 0; beats = 0; n = 0; fin = 0; ab = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      n++;
      r.irdy_low++;
      if (rem > 1) r.frame_low++; else r.fhil++;
`ifdef PCI_DEVSEL_CHECK_EN
      if (!seen) begin
        if (!dsel_seq[i]) seen = 1;
        else begin
          dcnt++;
          if (dcnt == DEVSEL_LIMIT_DEF) begin ab = 1; fin = 1; continue; end
        end
      end
`endif
      if (!trdy_seq[i]) begin
        beats++; rem--; waits = 0;
        if (rem == 0) begin r.done_n = 1; r.end_cyc = n + 1; fin = 1; end
      end else begin
        waits++;
        if (waits == TRDY_TIMEOUT_DEF) begin ab = 1; fin = 1; end
      end
    end
    if (ab) begin r.abort_n = 1; r.end_cyc = n + 2; r.irdy_low++; r.fhil++; end
    r.beat = (beats > 15) ? 15 : beats;
    return r;
  endfunction

  // Drives one transaction and records what the bus showed; cyc counts edges after the grant edge.
  task automatic run_txn(input int len, input int gap, input bit poke, output res_t o);
    o = '{default: 0};
    o.end_cyc = -1; o.beat = -1;
    @(negedge clk); start = 1'b1; burst_len = len[3:0];
    @(negedge clk); start = 1'b0; o.busy0 = int'(busy); o.req0 = int'(bus._req);
    @(negedge clk); o.req1 = int'(bus._req);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (bus._req !== 1'b0) o.req_err++;
    end
    bus._gnt = 1'b0;
    @(posedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!bus._frame) o.frame_low++;
      if (!bus._irdy) o.irdy_low++;
      if (bus._frame && !bus._irdy) o.fhil++;
      if (done) begin o.done_n++; if (o.end_cyc < 0) o.end_cyc = cyc; end
      if (abort) begin o.abort_n++; if (o.end_cyc < 0) o.end_cyc = cyc; end
      if (done && abort) o.both++;
      if (!busy) begin
        o.idle_ok = int'(bus._req && bus._frame && bus._irdy);
        o.beat = int'(beat);
        o.fin = 1;
        break;
      end
      bus._gnt    = 1'b1;
      bus._trdy   = (cyc >= 1 && cyc <= 200) ? trdy_seq[cyc-1] : 1'b1;
      bus._devsel = (cyc >= 1 && cyc <= 200) ? dsel_seq[cyc-1] : 1'b1;
      start       = poke && (cyc == 3);
    end
    start = 1'b0; bus._gnt = 1'b1; bus._trdy = 1'b1; bus._devsel = 1'b1;
  endtask

  task automatic fill_seq(input bit t, input bit d);
    for (int i = 0; i < 200; i++) begin trdy_seq[i] = t; dsel_seq[i] = d; end
  endtask

  task automatic test_reset();
    int bad;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus._req, bus._frame, bus._irdy, busy, done, abort, beat} !== {3'b111, 3'b000, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_init: got req/frame/irdy=%b%b%b busy=%b done=%b abort=%b beat=%0d, want 111 0 0 0 0",
               bus._req, bus._frame, bus._irdy, busy, done, abort, beat);
    end
    reset = 1'b0;
    // Reset in the middle of a 5-beat burst after one beat has completed.
    @(negedge clk); start = 1'b1; burst_len = 4'd5;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 10 && bus._req !== 1'b0; i++) @(negedge clk);
    bus._gnt = 1'b0;
    @(negedge clk); bus._gnt = 1'b1;
    @(negedge clk); bus._trdy = 1'b0;
    @(negedge clk); bus._trdy = 1'b1;
    @(negedge clk);
    bad = 0;
    reset = 1'b1;
    repeat (2) begin @(negedge clk); if (done || abort) bad++; end
    n_tests++;
    if ({bus._req, bus._frame, bus._irdy, busy, beat} !== {3'b111, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_data: got req/frame/irdy=%b%b%b busy=%b beat=%0d, want 111 0 0",
               bus._req, bus._frame, bus._irdy, busy, beat);
    end
    reset = 1'b0;
    repeat (4) begin @(negedge clk); if (done || abort || busy) bad++; end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d cycles with done/abort/busy, want 0", bad);
    end
  endtask

  task automatic test_single_beat();
    res_t o, e;
    fill_seq(1'b0, 1'b0);
    e = model(1);
    run_txn(1, 0, 1'b0, o);
    n_tests++;
    if ({o.frame_low, o.irdy_low, o.done_n, o.abort_n, o.end_cyc, o.beat} !== {32'd1, 32'd1, 32'd1, 32'd0, 32'd2, 32'd1}) begin
      n_fail++;
      $display("FAIL single_beat: got frame_low=%0d irdy_low=%0d done=%0d abort=%0d end=%0d beat=%0d, want 1 1 1 0 2 1",
               o.frame_low, o.irdy_low, o.done_n, o.abort_n, o.end_cyc, o.beat);
    end
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL single_model: got %p, want %p", o, e); end
  endtask

  task automatic test_burst_wait();
    res_t o;
    fill_seq(1'b0, 1'b0);
    trdy_seq[1] = 1'b1;
    run_txn(4, 1, 1'b0, o);
    n_tests++;
    if ({o.frame_low, o.irdy_low, o.fhil, o.done_n, o.abort_n, o.end_cyc, o.beat} !==
        {32'd5, 32'd5, 32'd1, 32'd1, 32'd0, 32'd6, 32'd4}) begin
      n_fail++;
      $display("FAIL burst_wait: got frame_low=%0d irdy_low=%0d fhil=%0d done=%0d abort=%0d end=%0d beat=%0d, want 5 5 1 1 0 6 4",
               o.frame_low, o.irdy_low, o.fhil, o.done_n, o.abort_n, o.end_cyc, o.beat);
    end
  endtask

  task automatic test_trdy_timeout();
    res_t o;
    fill_seq(1'b1, 1'b0);
    run_txn(3, 2, 1'b0, o);
    n_tests++;
    if ({o.frame_low, o.irdy_low, o.fhil, o.done_n, o.abort_n, o.end_cyc, o.beat, o.idle_ok} !==
        {32'd9, 32'd9, 32'd1, 32'd0, 32'd1, 32'd10, 32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL trdy_timeout: got frame_low=%0d irdy_low=%0d fhil=%0d done=%0d abort=%0d end=%0d beat=%0d idle=%0d, want 9 9 1 0 1 10 0 1",
               o.frame_low, o.irdy_low, o.fhil, o.done_n, o.abort_n, o.end_cyc, o.beat, o.idle_ok);
    end
  endtask

  task automatic test_ignored();
    res_t o, e;
    int bad;
    bad = 0;
    @(negedge clk); start = 1'b1; burst_len = 4'd0;
    @(negedge clk); start = 1'b0;
    repeat (4) begin @(negedge clk); if (busy || !bus._req) bad++; end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL zero_len: got %0d active cycles, want 0", bad); end
    fill_seq(1'b0, 1'b0);
    e = model(2);
    run_txn(2, 0, 1'b1, o);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL busy_start_txn: got %p, want %p", o, e); end
    bad = 0;
    repeat (5) begin @(negedge clk); if (busy || !bus._req) bad++; end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL busy_start_queued: got %0d active cycles, want 0", bad); end
  endtask

`ifdef PCI_DEVSEL_CHECK_EN
  task automatic test_devsel();
    res_t o;
    fill_seq(1'b1, 1'b1);
    run_txn(3, 0, 1'b0, o);
    n_tests++;
    if ({o.abort_n, o.done_n, o.end_cyc, o.beat} !== {32'd1, 32'd0, 32'd7, 32'd0}) begin
      n_fail++;
      $display("FAIL devsel_abort: got abort=%0d done=%0d end=%0d beat=%0d, want 1 0 7 0", o.abort_n, o.done_n, o.end_cyc, o.beat);
    end
    fill_seq(1'b0, 1'b0);
    dsel_seq[0] = 1'b1;
    run_txn(6, 1, 1'b0, o);
    n_tests++;
    if ({o.abort_n, o.done_n, o.end_cyc, o.beat} !== {32'd0, 32'd1, 32'd7, 32'd6}) begin
      n_fail++;
      $display("FAIL devsel_claim: got abort=%0d done=%0d end=%0d beat=%0d, want 0 1 7 6", o.abort_n, o.done_n, o.end_cyc, o.beat);
    end
  endtask
`endif

  task automatic test_random();
    res_t o, e;
    int len, i, run, d0;
    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(1, 15);
      i = 0;
      while (i < 200) begin
        if ($urandom_range(0, 11) == 0) begin
          run = $urandom_range(1, 10);
          for (int k = 0; k < run && i < 200; k++) begin trdy_seq[i] = 1'b1; i++; end
        end else begin
          trdy_seq[i] = ($urandom_range(0, 9) < 3);
          i++;
        end
      end
      d0 = $urandom_range(0, 6);
      for (int k = 0; k < 200; k++) dsel_seq[k] = (k < d0) ? 1'b1 : 1'($urandom_range(0, 1));
      e = model(len);
      run_txn(len, $urandom_range(0, 3), 1'($urandom_range(0, 1)), o);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL random_txn%0d len=%0d: got %p, want %p", t, len, o, e); end
    end
  endtask

  initial begin
    bus._gnt = 1'b1; bus._trdy = 1'b1; bus._devsel = 1'b1;
    test_reset();
    test_single_beat();
    test_burst_wait();
    test_trdy_timeout();
    test_ignored();
`ifdef PCI_DEVSEL_CHECK_EN
    test_devsel();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
